// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the 160x120 framebuffer write port between two painters and a clear engine
// Ports: Clck/Reset (sync, active-high); clear_req in, clear_busy/clear_done out;
//        rN_valid/rN_last/rN_x/rN_y/rN_color in, rN_ready out (N = 0 board, 1 overlay);
//        x/y/colour/plot: registered write port toward the VGA adapter.
module plot_arbiter #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7,
  parameter int COLOR_BITS = 3,
  parameter logic [COLOR_BITS-1:0] BG_COLOR = 3'b000
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  r0_valid,
  input  logic                  r0_last,
  input  logic [X_BITS-1:0]     r0_x,
  input  logic [Y_BITS-1:0]     r0_y,
  input  logic [COLOR_BITS-1:0] r0_color,
  output logic                  r0_ready,
  input  logic                  r1_valid,
  input  logic                  r1_last,
  input  logic [X_BITS-1:0]     r1_x,
  input  logic [Y_BITS-1:0]     r1_y,
  input  logic [COLOR_BITS-1:0] r1_color,
  output logic                  r1_ready,
  output logic [X_BITS-1:0]     x,
  output logic [Y_BITS-1:0]     y,
  output logic [COLOR_BITS-1:0] colour,
  output logic                  plot
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_G0 = 2'd2, S_G1 = 2'd3;
  logic [1:0]            r_state;
  logic                  r_pend, r_last_served;
  logic [X_BITS-1:0]     r_cx;
  logic [Y_BITS-1:0]     r_cy;
  logic                  w_sel1, w_acc, w_blast, w_in, w_xend, w_cend;
  logic [X_BITS-1:0]     w_bx;
  logic [Y_BITS-1:0]     w_by;
  logic [COLOR_BITS-1:0] w_bc;
  always_comb begin
    r0_ready   = (r_state == S_G0) && r0_valid;
    r1_ready   = (r_state == S_G1) && r1_valid;
    clear_busy = r_state == S_CLEAR;
    w_sel1     = r_state == S_G1;
    w_acc      = r0_ready || r1_ready;
    w_bx       = w_sel1 ? r1_x : r0_x;
    w_by       = w_sel1 ? r1_y : r0_y;
    w_bc       = w_sel1 ? r1_color : r0_color;
    w_blast    = w_sel1 ? r1_last : r0_last;
    w_in       = (w_bx < X_BITS'(SCR_W)) && (w_by < Y_BITS'(SCR_H));
    w_xend     = r_cx == X_BITS'(SCR_W - 1);
    w_cend     = w_xend && (r_cy == Y_BITS'(SCR_H - 1));
  end
  always_ff @(posedge Clck) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_pend        <= 1'b0;
      r_last_served <= 1'b1;
      r_cx          <= '0;
      r_cy          <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      clear_done    <= 1'b0;
    end else begin
      plot       <= 1'b0;
      clear_done <= 1'b0;
      r_pend     <= r_pend || clear_req;
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_state <= S_CLEAR;
            r_pend  <= 1'b0;
            r_cx    <= '0;
            r_cy    <= '0;
          end else if (r0_valid && (!r1_valid || r_last_served)) r_state <= S_G0;
          else if (r1_valid) r_state <= S_G1;
        end
        S_CLEAR: begin
          // requests arriving mid-sweep are absorbed into the running sweep
          r_pend <= 1'b0;
          x      <= r_cx;
          y      <= r_cy;
          colour <= BG_COLOR;
          plot   <= 1'b1;
          r_cx   <= w_xend ? '0 : r_cx + X_BITS'(1);
          r_cy   <= w_xend ? r_cy + Y_BITS'(1) : r_cy;
          if (w_cend) begin
            r_state    <= S_IDLE;
            clear_done <= 1'b1;
          end
        end
        default: begin
          if (w_acc) begin
            // off-screen beats are consumed but never reach the framebuffer
            plot <= w_in;
            if (w_in) begin
              x      <= w_bx;
              y      <= w_by;
              colour <= w_bc;
            end
            if (w_blast) begin
              r_last_served <= w_sel1;
              r_state       <= S_IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed self-checking bench for plot_arbiter
module tb_plot_arbiter;
  logic       Clck = 1'b0;
  logic       Reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       clear_busy, clear_done;
  logic       r0_valid = 1'b0, r0_last = 1'b0, r0_ready;
  logic [7:0] r0_x = '0;
  logic [6:0] r0_y = '0;
  logic [2:0] r0_color = '0;
  logic       r1_valid = 1'b0, r1_last = 1'b0, r1_ready;
  logic [7:0] r1_x = '0;
  logic [6:0] r1_y = '0;
  logic [2:0] r1_color = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  int checks = 0;
  int failures = 0;

  plot_arbiter dut (
    .Clck(Clck), .Reset(Reset), .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .r0_valid(r0_valid), .r0_last(r0_last), .r0_x(r0_x), .r0_y(r0_y), .r0_color(r0_color), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_last(r1_last), .r1_x(r1_x), .r1_y(r1_y), .r1_color(r1_color), .r1_ready(r1_ready),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 Clck = ~Clck;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clck);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || clear_busy !== 1'b0 || clear_done !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state plot=%0b x=%0d y=%0d c=%0d busy=%0b done=%0b rdy=%0b%0b want all zero", plot, x, y, colour, clear_busy, clear_done, r0_ready, r1_ready);
    end
  endtask

  task automatic test_burst();
    r0_valid = 1'b1; r0_last = 1'b0; r0_x = 8'd1; r0_y = 7'd1; r0_color = 3'b100;
    #1;
    checks++;
    if (r0_ready !== 1'b0) begin failures++; $display("FAIL burst_idle_ready got=%0b want=0", r0_ready); end
    tick();
    checks++;
    if (r0_ready !== 1'b1 || plot !== 1'b0) begin failures++; $display("FAIL burst_grant ready=%0b plot=%0b want 1 0", r0_ready, plot); end
    tick();
    r0_x = 8'd2;
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd1 || y !== 7'd1 || colour !== 3'b100 || r0_ready !== 1'b1) begin
      failures++; $display("FAIL burst_b1 plot=%0b x=%0d y=%0d c=%0d rdy=%0b want 1 1 1 4 1", plot, x, y, colour, r0_ready);
    end
    tick();
    r0_x = 8'd3; r0_last = 1'b1;
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd2 || y !== 7'd1 || r0_ready !== 1'b1) begin
      failures++; $display("FAIL burst_b2 plot=%0b x=%0d y=%0d rdy=%0b want 1 2 1 1", plot, x, y, r0_ready);
    end
    tick();
    r0_valid = 1'b0; r0_last = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd3 || y !== 7'd1 || colour !== 3'b100 || r0_ready !== 1'b0) begin
      failures++; $display("FAIL burst_b3 plot=%0b x=%0d y=%0d c=%0d rdy=%0b want 1 3 1 4 0", plot, x, y, colour, r0_ready);
    end
    tick();
    checks++;
    if (plot !== 1'b0 || x !== 8'd3) begin failures++; $display("FAIL burst_hold plot=%0b x=%0d want 0 3", plot, x); end
  endtask

  task automatic test_alternate();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    r0_valid = 1'b1; r0_last = 1'b1; r0_x = 8'd10; r0_y = 7'd10; r0_color = 3'd1;
    r1_valid = 1'b1; r1_last = 1'b1; r1_x = 8'd20; r1_y = 7'd20; r1_color = 3'd2;
    #1;
    checks++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL alt_idle rdy=%0b%0b want 00", r0_ready, r1_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (r0_ready !== (i % 2 == 0) || r1_ready !== (i % 2 == 1)) begin
        failures++; $display("FAIL alt_grant%0d rdy0=%0b rdy1=%0b want %0b %0b", i, r0_ready, r1_ready, i % 2 == 0, i % 2 == 1);
      end
      tick();
      if (i == 3) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      #1;
      checks++;
      if (plot !== 1'b1 || x !== ((i % 2 == 1) ? 8'd20 : 8'd10) || colour !== ((i % 2 == 1) ? 3'd2 : 3'd1) || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        failures++; $display("FAIL alt_plot%0d plot=%0b x=%0d c=%0d rdy=%0b%0b want 1 %0d %0d 00", i, plot, x, colour, r0_ready, r1_ready, (i % 2 == 1) ? 20 : 10, (i % 2 == 1) ? 2 : 1);
      end
    end
    tick();
  endtask

  task automatic test_lock();
    r1_valid = 1'b1; r1_last = 1'b0; r1_x = 8'd30; r1_y = 7'd5; r1_color = 3'd5;
    tick();
    r0_valid = 1'b1; r0_last = 1'b1; r0_x = 8'd40; r0_y = 7'd5; r0_color = 3'd6;
    #1;
    checks++;
    if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin failures++; $display("FAIL lock_grant rdy0=%0b rdy1=%0b want 0 1", r0_ready, r1_ready); end
    tick();
    r1_valid = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd30 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
      failures++; $display("FAIL lock_b1 plot=%0b x=%0d rdy=%0b%0b want 1 30 00", plot, x, r0_ready, r1_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (r0_ready !== 1'b0 || plot !== 1'b0) begin failures++; $display("FAIL lock_wait%0d rdy0=%0b plot=%0b want 0 0", i, r0_ready, plot); end
    end
    r1_valid = 1'b1; r1_x = 8'd31; r1_last = 1'b1;
    #1;
    checks++;
    if (r1_ready !== 1'b1) begin failures++; $display("FAIL lock_resume rdy1=%0b want 1", r1_ready); end
    tick();
    r1_valid = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd31 || colour !== 3'd5 || r0_ready !== 1'b0) begin
      failures++; $display("FAIL lock_last plot=%0b x=%0d c=%0d rdy0=%0b want 1 31 5 0", plot, x, colour, r0_ready);
    end
    tick();
    checks++;
    if (r0_ready !== 1'b1) begin failures++; $display("FAIL lock_r0_turn rdy0=%0b want 1", r0_ready); end
    tick();
    r0_valid = 1'b0;
    checks++;
    if (plot !== 1'b1 || x !== 8'd40 || colour !== 3'd6) begin failures++; $display("FAIL lock_r0_plot plot=%0b x=%0d c=%0d want 1 40 6", plot, x, colour); end
    tick();
  endtask

  task automatic test_oob();
    r0_valid = 1'b1; r0_last = 1'b1; r0_x = 8'd160; r0_y = 7'd5; r0_color = 3'd7;
    tick();
    checks++;
    if (r0_ready !== 1'b1) begin failures++; $display("FAIL oob_ready rdy0=%0b want 1", r0_ready); end
    tick();
    r0_valid = 1'b0;
    checks++;
    if (plot !== 1'b0 || x !== 8'd40) begin failures++; $display("FAIL oob_noplot plot=%0b x=%0d want 0 40", plot, x); end
    r1_valid = 1'b1; r1_last = 1'b1; r1_x = 8'd7; r1_y = 7'd8; r1_color = 3'd3;
    #1;
    checks++;
    if (r1_ready !== 1'b0) begin failures++; $display("FAIL oob_idle rdy1=%0b want 0", r1_ready); end
    tick();
    checks++;
    if (r1_ready !== 1'b1) begin failures++; $display("FAIL oob_released rdy1=%0b want 1", r1_ready); end
    tick();
    r1_valid = 1'b0;
    checks++;
    if (plot !== 1'b1 || x !== 8'd7 || y !== 7'd8) begin failures++; $display("FAIL oob_next plot=%0b x=%0d y=%0d want 1 7 8", plot, x, y); end
    tick();
  endtask

  task automatic test_clear();
    int bad = 0;
    int first_bad = -1;
    r0_valid = 1'b1; r0_last = 1'b0; r0_x = 8'd5; r0_y = 7'd6; r0_color = 3'd7;
    tick();
    clear_req = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1) begin failures++; $display("FAIL clr_burst_grant rdy0=%0b want 1", r0_ready); end
    tick();
    clear_req = 1'b0; r0_x = 8'd6; r0_last = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || clear_busy !== 1'b0) begin failures++; $display("FAIL clr_no_preempt rdy0=%0b busy=%0b want 1 0", r0_ready, clear_busy); end
    tick();
    r0_valid = 1'b0; r0_last = 1'b0;
    checks++;
    if (plot !== 1'b1 || x !== 8'd6 || y !== 7'd6 || clear_busy !== 1'b0) begin
      failures++; $display("FAIL clr_burst_end plot=%0b x=%0d y=%0d busy=%0b want 1 6 6 0", plot, x, y, clear_busy);
    end
    tick();
    checks++;
    if (clear_busy !== 1'b1 || plot !== 1'b0) begin failures++; $display("FAIL clr_start busy=%0b plot=%0b want 1 0", clear_busy, plot); end
    tick();
    for (int n = 0; n < 19200; n++) begin
      if (plot !== 1'b1 || x !== 8'(n % 160) || y !== 7'(n / 160) || colour !== 3'b000 || clear_done !== (n == 19199) || clear_busy !== (n != 19199)) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
      clear_req = (n == 5000);
      tick();
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL clr_sweep bad_pixels=%0d first_bad=%0d want 0", bad, first_bad); end
    checks++;
    if (plot !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      failures++; $display("FAIL clr_after plot=%0b busy=%0b done=%0b want 0 0 0", plot, clear_busy, clear_done);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (plot !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL clr_no_resweep active_cycles=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 500; i++) tick();
    checks++;
    if (plot !== 1'b1 || x !== 8'd20 || y !== 7'd3 || clear_busy !== 1'b1) begin
      failures++; $display("FAIL rmc_pixel500 plot=%0b x=%0d y=%0d busy=%0b want 1 20 3 1", plot, x, y, clear_busy);
    end
    Reset = 1'b1; clear_req = 1'b1;
    tick();
    checks++;
    if (plot !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      failures++; $display("FAIL rmc_abort plot=%0b busy=%0b done=%0b want 0 0 0", plot, clear_busy, clear_done);
    end
    Reset = 1'b0; clear_req = 1'b0;
    tick();
    tick();
    checks++;
    if (clear_busy !== 1'b0 || plot !== 1'b0) begin failures++; $display("FAIL rmc_req_in_reset busy=%0b plot=%0b want 0 0", clear_busy, plot); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    r0_valid = 1'b1; r0_last = 1'b1; r0_x = 8'd50; r0_y = 7'd50; r0_color = 3'd2;
    #1;
    checks++;
    if (r0_ready !== 1'b0) begin failures++; $display("FAIL rmc_pend_idle rdy0=%0b want 0", r0_ready); end
    tick();
    checks++;
    if (clear_busy !== 1'b1 || r0_ready !== 1'b0) begin failures++; $display("FAIL rmc_clear_wins busy=%0b rdy0=%0b want 1 0", clear_busy, r0_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (plot !== 1'b1 || x !== 8'(i) || y !== 7'd0 || colour !== 3'b000) begin
        failures++; $display("FAIL rmc_restart%0d plot=%0b x=%0d y=%0d c=%0d want 1 %0d 0 0", i, plot, x, y, colour, i);
      end
    end
    Reset = 1'b1; r0_valid = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_alternate();
    test_lock();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Owns the single framebuffer write port (x, y, colour, plot) of the 160x120 VGA adapter.
- Shares that port between two pixel requesters: requester 0 is the board painter; requester 1 is the pointer/status overlay painter.
- Contains an internal clear-screen engine that sweeps every pixel with a background colour on command.
- Sits between the painters and the VGA adapter in the low-level display layer.

Parameters:
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels
X_BITS, 8, x coordinate width
Y_BITS, 7, y coordinate width
COLOR_BITS, 3, colour width (1 bit per channel, RGB)
BG_COLOR, 3'b000, colour written by the clear engine

Ports:
Clck  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
clear_req  in  1  single-cycle request to clear the whole screen
clear_busy  out  1  high while the clear engine owns the port
clear_done  out  1  single-cycle pulse on the cycle the last clear pixel is plotted
r0_valid  in  1  requester 0 has a pixel
r0_last  in  1  requester 0 beat is the last of its burst
r0_x  in  X_BITS  requester 0 x
r0_y  in  Y_BITS  requester 0 y
r0_color  in  COLOR_BITS  requester 0 colour
r0_ready  out  1  requester 0 beat accepted this cycle
r1_valid, r1_last, r1_x, r1_y, r1_color, r1_ready  same widths and meanings for requester 1
x  out  X_BITS  registered plot x
y  out  Y_BITS  registered plot y
colour  out  COLOR_BITS  registered plot colour
plot  out  1  registered write strobe to the VGA adapter

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; x = y = colour = 0; plot = 0.
  - clear_busy = 0; clear_done = 0.
  - The pending-clear flag is cleared and last_served = 1, so requester 0 wins the first tie.
  - Reset asserted mid-burst or mid-clear aborts the operation; no plot occurs on the following cycle.
- States: IDLE, CLEAR, G0, G1.
- IDLE, priority order:
  - (a) pending clear -> CLEAR;
  - (b) only one valid -> grant that requester;
  - (c) both valid -> grant the requester other than last_served;
  - (d) else stay in IDLE.
  - The grant takes effect the next cycle; no beat is accepted in IDLE.
- G0 / G1:
  - rN_ready = rN_valid while in GN. Combinational; all other readies are 0.
  - A beat is accepted when valid and ready.
  - On an accepted beat with rN_last = 1: set last_served = N, then go to IDLE.
  - Otherwise hold the grant. The burst is locked; the other requester waits however long valid is low.
- Latency: an accepted beat appears on x/y/colour with plot = 1 exactly one cycle later. The output registers hold their values when plot = 0.
- Out-of-range beats (x >= SCR_W or y >= SCR_H) are accepted (ready = 1) but produce plot = 0. The burst logic still honours last.
- clear_req handling:
  - clear_req sets the pending flag in any state, and a clear_req in the same cycle as Reset is ignored.
  - An active burst is never pre-empted; the clear starts at the next IDLE.
  - clear_req while in CLEAR, or while a clear is already pending, is absorbed. Exactly one clear runs.
- CLEAR:
  - clear_busy = 1 from the cycle the state is CLEAR.
  - Emits one pixel per cycle with colour = BG_COLOR, in x-fastest raster order from (0,0) to (SCR_W-1, SCR_H-1): 19200 plot cycles with no gaps.
  - x wraps to 0 and y increments after x = SCR_W-1.
  - clear_done pulses together with plot of (SCR_W-1, SCR_H-1).
  - The next cycle is IDLE with clear_busy = 0 and the pending flag cleared. A clear_req received during CLEAR does not re-trigger.
- Simultaneous pending clear and requester valid in IDLE: the clear wins.
- Throughput: at most one plot per cycle. One idle cycle separates consecutive bursts because of the IDLE arbitration cycle.

Test Plan:
- Reset, then r0 sends 3 beats (last on the 3rd) at (1,1),(2,1),(3,1) colour 3'b100 -> plot high 3 consecutive cycles with matching coordinates, one cycle after each ready; state returns to IDLE.
- r0 and r1 both hold valid continuously with single-beat bursts -> grants alternate r0, r1, r0, r1; each plot is separated by one IDLE cycle.
- r1 mid-burst (last not yet seen), r1_valid dropped for 5 cycles while r0_valid is high -> r0_ready stays 0 and r1 keeps the grant until its last beat.
- clear_req during an r0 burst -> the burst completes, then 19200 consecutive plots of 3'b000 in raster order, and clear_done coincides with (159,119). A second clear_req mid-clear adds no extra sweep.
- r0 beat at x=160,y=5 with last = 1 -> r0_ready = 1, plot stays 0, grant released.
- Reset asserted at clear pixel 500 -> next cycle plot = 0 and clear_busy = 0. A fresh clear_req restarts the sweep from (0,0).
